// File: rtl/dcache_if.sv
// dcache_if: pipeline request/response and backing-memory signals of dcache_ctrl.
// The cache controller uses the slave modport; the pipeline/memory side uses master.
interface dcache_if;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        rd;
  logic        wr;
  logic [15:0] rdata;
  logic        done;
  logic        stall;
  logic        err;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  addr, wdata, rd, wr, mem_rdata, mem_ack,
    output rdata, done, stall, err, mem_req, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output addr, wdata, rd, wr, mem_rdata, mem_ack,
    input  rdata, done, stall, err, mem_req, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int INDEX_BITS     = 5,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 13 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_r, stateNext_s;
  logic [1:0]            cnt_r, cntNext_s;
  logic                  gap_r;
  logic [15:1]           missAddr_r;
  logic [15:0]           missWdata_r;
  logic                  missWr_r;

  logic [15:0]           dataArr_r [LINES][WORDS_PER_LINE];
  logic [TAG_BITS-1:0]   tagArr_r  [LINES];
  logic [LINES-1:0]      valid_r;
  logic [LINES-1:0]      dirty_r;

  logic [INDEX_BITS-1:0] reqIdx_s, missIdx_s;
  logic [TAG_BITS-1:0]   reqTag_s, missTag_s;
  logic [1:0]            reqOff_s, missOff_s;
  logic                  anyReq_s, reqErr_s, hit_s, missEntry_s;
  logic                  memReq_s, ackOk_s, ackErr_s;
  logic                  fillLast_s, hitStore_s, doneStore_s;
  logic                  done_s, stall_s, memWr_s;
  logic [15:0]           memAddr_s, memWdata_s, rdata_s;

  assign reqIdx_s  = bus.addr[3 +: INDEX_BITS];
  assign reqTag_s  = bus.addr[15 -: TAG_BITS];
  assign reqOff_s  = bus.addr[2:1];
  assign missIdx_s = missAddr_r[3 +: INDEX_BITS];
  assign missTag_s = missAddr_r[15 -: TAG_BITS];
  assign missOff_s = missAddr_r[2:1];

  assign anyReq_s    = bus.rd | bus.wr;
  assign reqErr_s    = (bus.rd & bus.wr) | (anyReq_s & bus.addr[0]);
  assign hit_s       = !rst && (state_r == IDLE) && anyReq_s && !reqErr_s &&
                       valid_r[reqIdx_s] && (tagArr_r[reqIdx_s] == reqTag_s);
  assign missEntry_s = !rst && (state_r == IDLE) && anyReq_s && !reqErr_s && !hit_s;

  // One idle cycle follows every acknowledged word, so an ack seen then is spurious.
  assign memReq_s    = ((state_r == WB) || (state_r == FILL)) && !gap_r;
  assign ackOk_s     = !rst && memReq_s && bus.mem_ack;
  assign ackErr_s    = ((state_r == WB) || (state_r == FILL)) && !memReq_s && bus.mem_ack;
  assign fillLast_s  = (state_r == FILL) && ackOk_s && (cnt_r == 2'd3);
  assign hitStore_s  = hit_s && bus.wr;
  assign doneStore_s = !rst && (state_r == DONE) && missWr_r;

  // Next-state, word counter and combinational outputs of the miss FSM.
  always_comb begin
    stateNext_s = state_r;
    cntNext_s   = cnt_r;
    done_s      = 1'b0;
    stall_s     = 1'b0;
    memWr_s     = 1'b0;
    memAddr_s   = 16'h0000;
    memWdata_s  = 16'h0000;
    rdata_s     = 16'h0000;
    case (state_r)
      IDLE: begin
        if (hit_s) begin
          done_s = 1'b1;
          if (bus.rd) rdata_s = dataArr_r[reqIdx_s][reqOff_s];
          else        rdata_s = 16'h0000;
        end else if (missEntry_s) begin
          stall_s     = 1'b1;
          cntNext_s   = 2'd0;
          stateNext_s = (valid_r[reqIdx_s] && dirty_r[reqIdx_s]) ? WB : FILL;
        end else begin
          stateNext_s = IDLE;
        end
      end
      WB: begin
        stall_s = 1'b1;
        memWr_s = memReq_s;
        if (memReq_s) begin
          memAddr_s  = {tagArr_r[missIdx_s], missIdx_s, cnt_r, 1'b0};
          memWdata_s = dataArr_r[missIdx_s][cnt_r];
        end else begin
          memAddr_s  = 16'h0000;
        end
        if (ackOk_s) begin
          cntNext_s   = cnt_r + 2'd1;
          stateNext_s = (cnt_r == 2'd3) ? FILL : WB;
        end else begin
          stateNext_s = WB;
        end
      end
      FILL: begin
        stall_s = 1'b1;
        if (memReq_s) memAddr_s = {missTag_s, missIdx_s, cnt_r, 1'b0};
        else          memAddr_s = 16'h0000;
        if (ackOk_s) begin
          cntNext_s   = cnt_r + 2'd1;
          stateNext_s = (cnt_r == 2'd3) ? DONE : FILL;
        end else begin
          stateNext_s = FILL;
        end
      end
      DONE: begin
        done_s      = 1'b1;
        stateNext_s = IDLE;
        if (!missWr_r) rdata_s = dataArr_r[missIdx_s][missOff_s];
        else           rdata_s = 16'h0000;
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  // Reset forces every output low immediately, even mid-transaction.
  assign bus.done      = done_s & ~rst;
  assign bus.stall     = stall_s & ~rst;
  assign bus.mem_req   = memReq_s & ~rst;
  assign bus.mem_wr    = memWr_s & ~rst;
  assign bus.mem_addr  = rst ? 16'h0000 : memAddr_s;
  assign bus.mem_wdata = rst ? 16'h0000 : memWdata_s;
  assign bus.rdata     = rst ? 16'h0000 : rdata_s;
  assign bus.err       = ~rst & (reqErr_s | ackErr_s);

  // FSM state, word counter and the request captured at miss entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 2'd0;
      gap_r       <= 1'b0;
      missAddr_r  <= 15'h0000;
      missWdata_r <= 16'h0000;
      missWr_r    <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      cnt_r   <= cntNext_s;
      gap_r   <= ackOk_s;
      if (missEntry_s) begin
        missAddr_r  <= bus.addr[15:1];
        missWdata_r <= bus.wdata;
        missWr_r    <= bus.wr;
      end else begin
        missWr_r    <= missWr_r;
      end
    end
  end

  // Valid and dirty flags per line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= {LINES{1'b0}};
      dirty_r <= {LINES{1'b0}};
    end else if (fillLast_s) begin
      valid_r[missIdx_s] <= 1'b1;
      dirty_r[missIdx_s] <= 1'b0;
    end else if (hitStore_s) begin
      dirty_r[reqIdx_s]  <= 1'b1;
    end else if (doneStore_s) begin
      dirty_r[missIdx_s] <= 1'b1;
    end else begin
      dirty_r <= dirty_r;
    end
  end

  // Data and tag storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (ackOk_s && (state_r == FILL)) begin
      dataArr_r[missIdx_s][cnt_r] <= bus.mem_rdata;
    end else if (hitStore_s) begin
      dataArr_r[reqIdx_s][reqOff_s] <= bus.wdata;
    end else if (doneStore_s) begin
      dataArr_r[missIdx_s][missOff_s] <= missWdata_r;
    end
    if (fillLast_s) begin
      tagArr_r[missIdx_s] <= missTag_s;
    end
  end

`ifdef DCACHE_STATS_EN
  // Saturating hit and miss-entry counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= 16'h0000;
      miss_cnt <= 16'h0000;
    end else begin
      if (hit_s && (hit_cnt != 16'hFFFF)) hit_cnt <= hit_cnt + 16'h0001;
      else                                hit_cnt <= hit_cnt;
      if (missEntry_s && (miss_cnt != 16'hFFFF)) miss_cnt <= miss_cnt + 16'h0001;
      else                                       miss_cnt <= miss_cnt;
    end
  end
`endif
endmodule
